hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core (F/D/E/M/W).
- Consumes decoded control bits from each stage plus register indices.
- Produces the following:
  - forwarding selects;
  - per-stage stall and flush signals;
  - a memory-wait FSM handshaking with data memory;
  - sticky timeout error and stall performance counters.
- Sits beside the datapath; no data passes through it.

Parameters:
- MEM_TIMEOUT, 16: max consecutive memory-wait cycles before error; must be ≥1.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- rsD, rtD  in  5  source regs in Decode
- rsE, rtE  in  5  source regs in Execute
- writeregE, writeregM, writeregW  in  5  destination reg per stage
- regwriteE, regwriteM, regwriteW  in  1  stage will write register file
- memtoregE, memtoregM  in  1  stage holds a load
- branchD, bneD  in  1  Decode holds beq/bne
- pcsrcD  in  1  branch resolved taken in Decode
- jumpD  in  1  Decode holds j/jal
- memreqM  in  1  Memory stage performs lw/sw
- memready  in  1  data memory completes access this cycle
- forwardAD, forwardBD  out  1  Decode comparator bypass from M
- forwardAE, forwardBE  out  2  ALU operand select: 00 regfile, 01 W result, 10 M ALU result
- stallF, stallD, stallE, stallM  out  1  hold stage register
- flushD, flushE, flushW  out  1  clear stage register to bubble
- memerr  out  1  sticky memory timeout flag
- lu_stalls, br_stalls, mem_stalls  out  CNT_W  stall-cycle counters

Behaviour:
- Register 0 never matches for forwarding or hazard detection.
- Forwarding (combinational):
  - forwardAE = 10 if regwriteM and writeregM==rsE.
  - Else forwardAE = 01 if regwriteW and writeregW==rsE.
  - Else forwardAE = 00.
  - forwardBE follows the same rule using rtE.
  - forwardAD = regwriteM and writeregM==rsD; forwardBD uses rtD.
- lu = memtoregE and (writeregE==rsD or writeregE==rtD).
- br = (branchD or bneD) and one of:
  - regwriteE and writeregE matches rsD or rtD;
  - memtoregM and writeregM matches rsD or rtD.
- FSM states: IDLE, WAIT, ERR.
  - IDLE → WAIT: memreqM and not memready.
  - WAIT → IDLE: memready.
  - WAIT → ERR: timer reaches MEM_TIMEOUT-1 without memready; sets memerr.
  - ERR → IDLE: next cycle unconditionally. The access is abandoned, memerr stays set, and the pipeline resumes.
  - Timer clears on entry to WAIT and increments each WAIT cycle.
- ms = memory stall, defined as either of:
  - (IDLE and memreqM and not memready);
  - (WAIT and not memready).
- Stall and flush priority, highest first:
  1. ms: stallF, stallD, stallE and stallM = 1; flushW = 1; flushE = 0; flushD = 0. lu and br are masked.
  2. lu or br: stallF = stallD = 1; flushE = 1; flushD = 0.
  3. Otherwise flushD = pcsrcD or jumpD.
  - All other stall and flush outputs are 0.
- Counters, each saturating at all-ones:
  - lu_stalls increments in a cycle where lu and not ms.
  - br_stalls increments where br and not lu and not ms.
  - mem_stalls increments where ms.
- Reset:
  - While reset is high, all stall, flush and forward outputs are 0.
  - Synchronously: FSM to IDLE, timer 0, memerr 0, all counters 0.
  - Reset mid-WAIT abandons the wait; no ERR is entered.
- Simultaneous events:
  - memready in the same cycle memreqM rises means no stall and no WAIT.
  - A taken branch during ms produces no flushD; the flush re-evaluates after ms clears.
- Latency: control outputs are combinational from the same-cycle inputs. FSM, timer, memerr and counter updates are visible the following cycle.

Test Plan:
- EX forwarding:
  - Stimulus: regwriteM=1, writeregM=8, rsE=8; in the same cycle regwriteW=1, writeregW=8.
  - Response: forwardAE=10 (M wins).
  - Stimulus: writeregM=0 with rsE=0.
  - Response: forwardAE=00.
- Load-use:
  - Stimulus: memtoregE=1, writeregE=9, rtD=9, one cycle.
  - Response: stallF=stallD=flushE=1; lu_stalls 0→1 next cycle.
- Branch hazard:
  - Stimulus: branchD=1, rsD=5, memtoregM=1, writeregM=5.
  - Response: stallD=1, flushE=1, br_stalls increments.
  - Stimulus: pcsrcD=1 with no hazard.
  - Response: flushD=1 only.
- Memory wait:
  - Stimulus: memreqM=1, memready low for 3 cycles then high.
  - Response: stallF..M=1 and flushW=1 for 3 cycles; mem_stalls=3; FSM returns to IDLE; concurrent lu is masked.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, memready held low.
  - Response: ERR after 4 WAIT cycles; memerr=1 and stays set; FSM back in IDLE; stalls drop.
- Reset mid-WAIT:
  - Stimulus: assert reset in cycle 2 of a wait.
  - Response: next cycle FSM IDLE, counters 0, memerr 0, all outputs 0 while reset is high.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: operand bypass
// selects, stall/flush generation, data-memory wait FSM and stall counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             bneD,
    input  logic             pcsrcD,
    input  logic             jumpD,
    input  logic             memreqM,
    input  logic             memready,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             memerr,
    output logic [CNT_W-1:0] lu_stalls,
    output logic [CNT_W-1:0] br_stalls,
    output logic [CNT_W-1:0] mem_stalls
);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    // The timer only has to reach MEM_TIMEOUT-1, so clog2(MEM_TIMEOUT) bits suffice.
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            memerr_q, memerr_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]      cnt_inc;
    logic            lu, br, ms;

    function automatic logic hit(input logic we, input logic [4:0] wr, input logic [4:0] src);
        return we && (wr != 5'd0) && (wr == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic wm,
                                           input logic [4:0] rm, input logic ww,
                                           input logic [4:0] rw);
        if (hit(wm, rm, src))      return 2'b10;
        else if (hit(ww, rw, src)) return 2'b01;
        else                       return 2'b00;
    endfunction

    always_comb begin
        lu = hit(memtoregE, writeregE, rsD) || hit(memtoregE, writeregE, rtD);
        br = (branchD || bneD) &&
             (hit(regwriteE, writeregE, rsD) || hit(regwriteE, writeregE, rtD) ||
              hit(memtoregM, writeregM, rsD) || hit(memtoregM, writeregM, rtD));
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        memerr_d = memerr_q;
        ms       = 1'b0;
        case (state_q)
            IDLE: begin
                if (memreqM && !memready) begin
                    ms      = 1'b1;
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                if (memready) begin
                    state_d = IDLE;
                end else begin
                    ms = 1'b1;
                    if (timer_q == TIMER_LAST) begin
                        state_d  = ERR;
                        memerr_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs are forced quiet while reset is held.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        if (!reset) begin
            forwardAE = fwd_sel(rsE, regwriteM, writeregM, regwriteW, writeregW);
            forwardBE = fwd_sel(rtE, regwriteM, writeregM, regwriteW, writeregW);
            forwardAD = hit(regwriteM, writeregM, rsD);
            forwardBD = hit(regwriteM, writeregM, rtD);
            if (ms) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (lu || br) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end else begin
                flushD = pcsrcD || jumpD;
            end
        end
    end

    assign cnt_inc[0] = lu && !ms;
    assign cnt_inc[1] = br && !lu && !ms;
    assign cnt_inc[2] = ms;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}}))
                    cnt_d[gi] = cnt_q[gi] + 1'b1;
            end

            always_ff @(posedge clk) begin
                if (reset) cnt_q[gi] <= '0;
                else       cnt_q[gi] <= cnt_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            memerr_q <= memerr_d;
        end
    end

    assign memerr     = memerr_q;
    assign lu_stalls  = cnt_q[0];
    assign br_stalls  = cnt_q[1];
    assign mem_stalls = cnt_q[2];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, bneD, pcsrcD, jumpD, memreqM, memready;
    logic       forwardAD, forwardBD, stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushW, memerr;
    logic [1:0] forwardAE, forwardBE;
    logic [CW-1:0] lu_stalls, br_stalls, mem_stalls;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .bneD(bneD), .pcsrcD(pcsrcD), .jumpD(jumpD),
        .memreqM(memreqM), .memready(memready),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .memerr(memerr),
        .lu_stalls(lu_stalls), .br_stalls(br_stalls), .mem_stalls(mem_stalls)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: is an access outstanding, how many wait cycles have
    // elapsed, and is this the single recovery cycle after a timeout.
    bit m_waiting, m_recover, m_err;
    int m_waited;
    int m_lu, m_br, m_mem;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m(input bit we, input logic [4:0] wr, input logic [4:0] src);
        return we && wr != 0 && wr == src;
    endfunction

    function automatic int fsel(input logic [4:0] src);
        if (m(regwriteM, writeregM, src)) return 2;
        if (m(regwriteW, writeregW, src)) return 1;
        return 0;
    endfunction

    function automatic bit model_ms();
        if (m_recover) return 0;
        return memreqM && !memready && !m_waiting || m_waiting && !memready;
    endfunction

    // Compare combinational outputs and registered state for the current cycle,
    // then advance the model across the next rising edge.
    task automatic step();
        bit lu, br, ms, hz, fd;
        #2;
        lu = m(memtoregE, writeregE, rsD) || m(memtoregE, writeregE, rtD);
        br = (branchD || bneD) && (m(regwriteE, writeregE, rsD) || m(regwriteE, writeregE, rtD) ||
                                   m(memtoregM, writeregM, rsD) || m(memtoregM, writeregM, rtD));
        ms = model_ms();
        hz = !ms && (lu || br);
        fd = !ms && !hz && (pcsrcD || jumpD);
        if (reset) begin
            check("fwdAE", forwardAE, 0); check("fwdBE", forwardBE, 0);
            check("fwdAD", forwardAD, 0); check("fwdBD", forwardBD, 0);
            check("stalls", {stallF, stallD, stallE, stallM}, 0);
            check("flushes", {flushD, flushE, flushW}, 0);
        end else begin
            check("fwdAE", forwardAE, fsel(rsE)); check("fwdBE", forwardBE, fsel(rtE));
            check("fwdAD", forwardAD, m(regwriteM, writeregM, rsD));
            check("fwdBD", forwardBD, m(regwriteM, writeregM, rtD));
            check("stallF", stallF, ms || hz); check("stallD", stallD, ms || hz);
            check("stallE", stallE, ms);       check("stallM", stallM, ms);
            check("flushD", flushD, fd);       check("flushE", flushE, hz);
            check("flushW", flushW, ms);
        end
        check("memerr", memerr, m_err);
        check("lu_stalls", lu_stalls, m_lu);
        check("br_stalls", br_stalls, m_br);
        check("mem_stalls", mem_stalls, m_mem);
        @(posedge clk);
        if (reset) begin
            m_waiting = 0; m_recover = 0; m_err = 0; m_waited = 0;
            m_lu = 0; m_br = 0; m_mem = 0;
        end else begin
            if (lu && !ms && m_lu < CMAX) m_lu++;
            if (br && !lu && !ms && m_br < CMAX) m_br++;
            if (ms && m_mem < CMAX) m_mem++;
            if (m_recover) begin
                m_recover = 0;
            end else if (m_waiting) begin
                if (memready) m_waiting = 0;
                else if (m_waited + 1 == TO) begin
                    m_waiting = 0; m_recover = 1; m_err = 1;
                end else m_waited++;
            end else if (memreqM && !memready) begin
                m_waiting = 1; m_waited = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
        {branchD, bneD, pcsrcD, jumpD, memreqM} = '0;
        memready = 1'b1;
    endtask

    task automatic rand_inputs(input int ready_pct);
        rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
        rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
        writeregE = 5'($urandom_range(0, 3));
        writeregM = 5'($urandom_range(0, 3));
        writeregW = 5'($urandom_range(0, 3));
        regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
        memtoregE = ($urandom_range(0, 3) == 0); memtoregM = ($urandom_range(0, 3) == 0);
        branchD = ($urandom_range(0, 3) == 0); bneD = ($urandom_range(0, 5) == 0);
        pcsrcD = 1'($urandom); jumpD = ($urandom_range(0, 5) == 0);
        memreqM = ($urandom_range(0, 2) == 0);
        memready = ($urandom_range(0, 99) < ready_pct);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        step(); step();
        reset = 1'b0;
        step();

        // EX forwarding: M beats W; register 0 never forwards.
        regwriteM = 1; writeregM = 8; regwriteW = 1; writeregW = 8; rsE = 8;
        step();
        check("dir_fwd_m_wins", forwardAE, 2);
        writeregM = 0; writeregW = 0; rsE = 0;
        step();
        check("dir_fwd_r0", forwardAE, 0);
        idle_inputs();

        // Load-use for one cycle.
        memtoregE = 1; writeregE = 9; rtD = 9;
        step();
        idle_inputs();
        step();
        check("dir_lu_count", lu_stalls, 1);

        // Branch hazard on a pending load, then a clean taken branch.
        branchD = 1; rsD = 5; memtoregM = 1; writeregM = 5;
        step();
        idle_inputs();
        pcsrcD = 1; branchD = 1;
        step();
        check("dir_br_count", br_stalls, 1);
        idle_inputs();

        // Memory wait of 3 cycles with a concurrent load-use that must be masked.
        memreqM = 1; memready = 0; memtoregE = 1; writeregE = 9; rtD = 9;
        repeat (3) step();
        memready = 1; memtoregE = 0;
        step();
        idle_inputs();
        step();
        check("dir_mem_count", mem_stalls, 3);

        // Timeout: ready held low until the access is abandoned.
        memreqM = 1; memready = 0;
        repeat (TO + 1) step();
        check("dir_memerr", memerr, 1);
        idle_inputs();
        step();

        // Reset in the second cycle of a wait.
        memreqM = 1; memready = 0;
        step(); step();
        reset = 1;
        step();
        reset = 0; idle_inputs();
        step();
        check("dir_rst_memerr", memerr, 0);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs((i / 500) % 2 ? 15 : 70);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
